// File: rtl/ntt_stage_sequencer_pkg.sv
// Shared constants and state encoding for the NTT stage sequencer and its tag pipe.
package ntt_stage_sequencer_pkg;

   localparam int DATAWIDTH = 16;
   localparam int DW        = DATAWIDTH + 1;
   localparam int P         = 17;
   localparam int NTT_LOGN  = 8;

   typedef enum logic [2:0] {
      SEQ_IDLE  = 3'd0,
      SEQ_RUN   = 3'd1,
      SEQ_DRAIN = 3'd2,
      SEQ_GAP   = 3'd3,
      SEQ_DONE  = 3'd4
   } seq_state_t;

   // Counter width that never collapses to zero bits.
   function automatic int ctr_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ntt_stage_sequencer_if.sv
// Sequencer-side bus: control handshake, coefficient RAM / twiddle ROM ports, butterfly issue and write-back tags.
interface ntt_stage_sequencer_if
   import ntt_stage_sequencer_pkg::*;
#(
   parameter int LOGN = NTT_LOGN
) ();

   logic            start;
   logic            busy;
   logic            done;
   logic            tag_err;
   logic            rd_en;
   logic [LOGN-1:0] rd_addr_a;
   logic [LOGN-1:0] rd_addr_b;
   logic [DW-1:0]   rd_data_a;
   logic [DW-1:0]   rd_data_b;
   logic [LOGN-2:0] tw_addr;
   logic [DW-1:0]   tw_data;
   logic [DW-1:0]   bf_xin;
   logic [DW-1:0]   bf_yin;
   logic [DW-1:0]   bf_wr;
   logic            bf_en;
   logic            bf_valid;
   logic            wb_valid;
   logic [LOGN-1:0] wb_addr_a;
   logic [LOGN-1:0] wb_addr_b;

   modport master (
      input  start,
      output busy, done, tag_err,
      output rd_en, rd_addr_a, rd_addr_b, tw_addr,
      input  rd_data_a, rd_data_b, tw_data,
      output bf_xin, bf_yin, bf_wr, bf_en,
      input  bf_valid,
      output wb_valid, wb_addr_a, wb_addr_b
   );

   modport slave (
      output start,
      input  busy, done, tag_err,
      input  rd_en, rd_addr_a, rd_addr_b, tw_addr,
      output rd_data_a, rd_data_b, tw_data,
      input  bf_xin, bf_yin, bf_wr, bf_en,
      output bf_valid,
      input  wb_valid, wb_addr_a, wb_addr_b
   );

endinterface

// File: rtl/ntt_tag_delay.sv
// Fixed-depth shift register carrying {valid, addr_a, addr_b} alongside the butterfly pipeline.
module ntt_tag_delay
   import ntt_stage_sequencer_pkg::*;
#(
   parameter int W     = 1,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] pipe [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= din;
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Issue controller for an in-place radix-2 NTT: walks stages, issues butterflies, tags write-backs.
// Optional NTT_SEQ_PERF_EN adds a saturating busy-cycle counter output cycle_cnt.
//
// state     | meaning
// SEQ_IDLE  | waiting for start
// SEQ_RUN   | one RAM read / butterfly issue per cycle for the current stage
// SEQ_DRAIN | waiting for every issued butterfly of the stage to return
// SEQ_GAP   | idle cycles so the last write-back lands in RAM
// SEQ_DONE  | one-cycle done pulse
module ntt_stage_sequencer
   import ntt_stage_sequencer_pkg::*;
#(
   parameter int LOGN   = NTT_LOGN,
   parameter int BF_LAT = 4,
   parameter int WB_GAP = 1
) (
   input  logic clk,
   input  logic reset,
`ifdef NTT_SEQ_PERF_EN
   output logic [31:0] cycle_cnt,
`endif
   ntt_stage_sequencer_if.master bus
);

   localparam int NB       = 1 << (LOGN - 1);
   localparam int BW       = LOGN - 1;
   localparam int SW       = ctr_w(LOGN);
   localparam int OW       = $clog2(BF_LAT + 2);
   localparam int GAP_LOAD = (WB_GAP > 0) ? WB_GAP - 1 : 0;
   localparam int GW       = ctr_w(GAP_LOAD + 1);

   seq_state_t      state, state_nxt;
   logic [SW-1:0]   s;
   logic [BW-1:0]   b;
   logic [GW-1:0]   gap_cnt;
   logic [OW-1:0]   outstanding;
   logic            rd_en, busy, done;
   logic            last_b, last_s, drained;
   logic            bf_en_q;
   logic            tag_err_q;
   logic [LOGN-1:0] addr_a_q, addr_b_q;
   logic [2*LOGN:0] tag_out;

   logic [BW-1:0]   bmask, j;
   logic [LOGN-1:0] h, addr_a, addr_b;
   logic [BW-1:0]   tw;
   logic [SW-1:0]   tw_sh;

   // For s = LOGN-1 the mask wraps to all ones, which is exactly h-1 truncated.
   always_comb begin
      bmask  = (BW'(1) << s) - BW'(1);
      j      = b & bmask;
      h      = LOGN'(1) << s;
      addr_a = (((({1'b0, b}) >> s) << s) << 1) | {1'b0, j};
      addr_b = addr_a | h;
      tw_sh  = SW'(LOGN - 1) - s;
      tw     = j << tw_sh;
   end

   assign last_b  = (b == BW'(NB - 1));
   assign last_s  = (s == SW'(LOGN - 1));
   assign drained = (outstanding == '0) && !bf_en_q;

   always_ff @(posedge clk) begin
      if (reset) state <= SEQ_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         SEQ_IDLE: begin
            if (bus.start) state_nxt = SEQ_RUN;
         end
         SEQ_RUN: begin
            rd_en = 1'b1;
            busy  = 1'b1;
            if (last_b) state_nxt = SEQ_DRAIN;
         end
         SEQ_DRAIN: begin
            busy = 1'b1;
            if (drained) state_nxt = SEQ_GAP;
         end
         SEQ_GAP: begin
            busy = 1'b1;
            if (gap_cnt == '0) state_nxt = last_s ? SEQ_DONE : SEQ_RUN;
         end
         SEQ_DONE: begin
            done      = 1'b1;
            state_nxt = SEQ_IDLE;
         end
         default: state_nxt = SEQ_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s       <= '0;
         b       <= '0;
         gap_cnt <= '0;
      end else begin
         case (state)
            SEQ_IDLE: begin
               if (bus.start) begin
                  s <= '0;
                  b <= '0;
               end
            end
            SEQ_RUN: begin
               if (!last_b) b <= b + BW'(1);
            end
            SEQ_DRAIN: gap_cnt <= GW'(GAP_LOAD);
            SEQ_GAP: begin
               if (gap_cnt != '0) begin
                  gap_cnt <= gap_cnt - GW'(1);
               end else if (!last_s) begin
                  s <= s + SW'(1);
                  b <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Capture the issued addresses with the read so the tag lines up with bf_en.
   always_ff @(posedge clk) begin
      if (reset) begin
         bf_en_q  <= 1'b0;
         addr_a_q <= '0;
         addr_b_q <= '0;
      end else begin
         bf_en_q  <= rd_en;
         addr_a_q <= rd_en ? addr_a : '0;
         addr_b_q <= rd_en ? addr_b : '0;
      end
   end

   ntt_tag_delay #(
      .W     (2 * LOGN + 1),
      .DEPTH (BF_LAT)
   ) u_tag_delay (
      .clk   (clk),
      .reset (reset),
      .din   ({bf_en_q, addr_a_q, addr_b_q}),
      .dout  (tag_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         outstanding <= '0;
         tag_err_q   <= 1'b0;
      end else begin
         case ({bf_en_q, bus.bf_valid})
            2'b10:   outstanding <= outstanding + OW'(1);
            2'b01:   if (outstanding != '0) outstanding <= outstanding - OW'(1);
            default: ;
         endcase
         if ((tag_out[2*LOGN] != bus.bf_valid) ||
             (bus.bf_valid && !bf_en_q && (outstanding == '0)))
            tag_err_q <= 1'b1;
      end
   end

`ifdef NTT_SEQ_PERF_EN
   always_ff @(posedge clk) begin
      if (reset)                                   cycle_cnt <= '0;
      else if ((state == SEQ_IDLE) && bus.start)   cycle_cnt <= '0;
      else if (busy && (cycle_cnt != 32'hFFFF_FFFF)) cycle_cnt <= cycle_cnt + 32'd1;
   end
`endif

   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.tag_err   = tag_err_q;
   assign bus.rd_en     = rd_en;
   assign bus.rd_addr_a = rd_en ? addr_a : '0;
   assign bus.rd_addr_b = rd_en ? addr_b : '0;
   assign bus.tw_addr   = rd_en ? tw : '0;
   assign bus.bf_en     = bf_en_q;
   assign bus.bf_xin    = bf_en_q ? bus.rd_data_a : '0;
   assign bus.bf_yin    = bf_en_q ? bus.rd_data_b : '0;
   assign bus.bf_wr     = bf_en_q ? bus.tw_data : '0;
   assign bus.wb_valid  = tag_out[2*LOGN];
   assign bus.wb_addr_a = tag_out[2*LOGN-1:LOGN];
   assign bus.wb_addr_b = tag_out[LOGN-1:0];

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Directed bench: N=8 NTT mod 17 with RAM/ROM and butterfly models around ntt_stage_sequencer.
module tb_ntt_stage_sequencer;
   import ntt_stage_sequencer_pkg::*;

   localparam int LOGN   = 3;
   localparam int N      = 8;
   localparam int NB     = 4;
   localparam int BF_LAT = 4;
   localparam int WB_GAP = 1;

   localparam int EXP_A[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
   localparam int EXP_B[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
   localparam int EXP_TW[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ntt_stage_sequencer_if #(.LOGN(LOGN)) bus ();

`ifdef NTT_SEQ_PERF_EN
   logic [31:0] cycle_cnt;
`endif

   ntt_stage_sequencer #(
      .LOGN   (LOGN),
      .BF_LAT (BF_LAT),
      .WB_GAP (WB_GAP)
   ) dut (
      .clk       (clk),
      .reset     (reset),
`ifdef NTT_SEQ_PERF_EN
      .cycle_cnt (cycle_cnt),
`endif
      .bus       (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- RAM / ROM model ----------------
   logic [DW-1:0] ram      [N];
   logic [DW-1:0] ram_init [N];
   logic [DW-1:0] tw_rom   [NB];
   logic          ram_load = 1'b0;
   logic [DW-1:0] rd_a_q, rd_b_q, tw_q;
   logic [DW-1:0] x_out, y_out;

   always @(posedge clk) begin
      if (bus.rd_en) begin
         rd_a_q <= ram[bus.rd_addr_a];
         rd_b_q <= ram[bus.rd_addr_b];
         tw_q   <= tw_rom[bus.tw_addr];
      end
      if (ram_load) begin
         for (int i = 0; i < N; i++) ram[i] <= ram_init[i];
      end else if (bus.wb_valid) begin
         ram[bus.wb_addr_a] <= x_out;
         ram[bus.wb_addr_b] <= y_out;
      end
   end

   assign bus.rd_data_a = rd_a_q;
   assign bus.rd_data_b = rd_b_q;
   assign bus.tw_data   = tw_q;

   // ---------------- butterfly model ----------------
   logic vp [BF_LAT];
   int   xp [BF_LAT];
   int   yp [BF_LAT];
   logic late;
   logic inject_req = 1'b0;
   logic inject_done;
   logic suppress;

   assign suppress = inject_req && !inject_done && vp[BF_LAT-1];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BF_LAT; i++) vp[i] <= 1'b0;
         late        <= 1'b0;
         inject_done <= 1'b0;
      end else begin
         vp[0] <= bus.bf_en;
         xp[0] <= (int'(bus.bf_xin) + (int'(bus.bf_wr) * int'(bus.bf_yin)) % P) % P;
         yp[0] <= (int'(bus.bf_xin) + P - (int'(bus.bf_wr) * int'(bus.bf_yin)) % P) % P;
         for (int i = 1; i < BF_LAT; i++) begin
            vp[i] <= vp[i-1];
            xp[i] <= xp[i-1];
            yp[i] <= yp[i-1];
         end
         late <= suppress;
         if (suppress) inject_done <= 1'b1;
      end
   end

   assign bus.bf_valid = (vp[BF_LAT-1] && !suppress) || late;
   assign x_out = DW'(xp[BF_LAT-1]);
   assign y_out = DW'(yp[BF_LAT-1]);

   // ---------------- run observation ----------------
   int sa [16];
   int sb [16];
   int st [16];
   int seq_n, done_cnt, busy_bad, busy_cycles, timeout, wb_n;
   int wb_last  [LOGN];
   int rd_first [LOGN];

   function automatic int bitrev3(input int v);
      return ((v & 1) << 2) | (v & 2) | ((v >> 2) & 1);
   endfunction

   function automatic int modpow(input int base, input int e);
      int r = 1;
      for (int i = 0; i < e; i++) r = (r * base) % P;
      return r;
   endfunction

   task automatic load_ram();
      for (int i = 0; i < N; i++) ram_init[i] = DW'(bitrev3(i) + 1);
      @(negedge clk);
      ram_load = 1'b1;
      @(negedge clk);
      ram_load = 1'b0;
   endtask

   // Pulses start and records what the sequencer does until a few cycles after done.
   task automatic run_one(input int repulse);
      int after;
      seq_n = 0; done_cnt = 0; busy_bad = 0; busy_cycles = 0; timeout = 1; wb_n = 0;
      after = -1;
      for (int i = 0; i < LOGN; i++) begin
         wb_last[i]  = -1000;
         rd_first[i] = -1000;
      end
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      for (int cyc = 0; cyc < 400; cyc++) begin
         bus.start = (cyc == repulse);
         if (bus.busy) busy_cycles++;
         if (done_cnt == 0 && !bus.busy && !bus.done) busy_bad++;
         if (bus.done) begin
            done_cnt++;
            if (after < 0) after = cyc;
         end
         if (bus.rd_en) begin
            if (seq_n < 16) begin
               sa[seq_n] = int'(bus.rd_addr_a);
               sb[seq_n] = int'(bus.rd_addr_b);
               st[seq_n] = int'(bus.tw_addr);
            end
            if ((seq_n % NB) == 0 && (seq_n / NB) < LOGN) rd_first[seq_n / NB] = cyc;
            seq_n++;
         end
         if (bus.wb_valid) begin
            wb_n++;
            if ((wb_n % NB) == 0 && (wb_n / NB) <= LOGN) wb_last[wb_n / NB - 1] = cyc;
         end
         if (after >= 0 && cyc >= after + 5) begin
            timeout = 0;
            break;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.done, bus.rd_en, bus.bf_en, bus.wb_valid, bus.tag_err} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 000000",
                  {bus.busy, bus.done, bus.rd_en, bus.bf_en, bus.wb_valid, bus.tag_err});
      end
      n_checks++;
      if ({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr} !== '0) begin
         n_fail++;
         $display("FAIL reset_addr: got a=%0d b=%0d tw=%0d expected 0 0 0",
                  bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr);
      end
      n_checks++;
      if (dut.outstanding !== '0) begin
         n_fail++;
         $display("FAIL reset_outstanding: got %0d expected 0", dut.outstanding);
      end
`ifdef NTT_SEQ_PERF_EN
      n_checks++;
      if (cycle_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_cycle_cnt: got %0d expected 0", cycle_cnt);
      end
`endif
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_addr_sequence();
      load_ram();
      run_one(-1);
      n_checks++;
      if (timeout !== 0) begin
         n_fail++;
         $display("FAIL addr_seq_timeout: got no done, expected done");
      end
      n_checks++;
      if (seq_n !== 12) begin
         n_fail++;
         $display("FAIL addr_seq_count: got %0d reads expected 12", seq_n);
      end
      for (int i = 0; i < 12; i++) begin
         n_checks++;
         if (sa[i] !== EXP_A[i] || sb[i] !== EXP_B[i] || st[i] !== EXP_TW[i]) begin
            n_fail++;
            $display("FAIL addr_seq[%0d]: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                     i, sa[i], sb[i], st[i], EXP_A[i], EXP_B[i], EXP_TW[i]);
         end
      end
   endtask

   task automatic test_stage_drain();
      load_ram();
      run_one(-1);
      for (int s = 0; s < LOGN - 1; s++) begin
         n_checks++;
         if (rd_first[s+1] - wb_last[s] <= WB_GAP) begin
            n_fail++;
            $display("FAIL stage_gap[%0d]: got next read %0d cycles after last wb, expected > %0d",
                     s, rd_first[s+1] - wb_last[s], WB_GAP);
         end
      end
      n_checks++;
      if (done_cnt !== 1) begin
         n_fail++;
         $display("FAIL done_count: got %0d expected 1", done_cnt);
      end
      n_checks++;
      if (busy_bad !== 0) begin
         n_fail++;
         $display("FAIL busy_gap: got %0d low cycles before done expected 0", busy_bad);
      end
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_after_done: got %0b expected 0", bus.busy);
      end
`ifdef NTT_SEQ_PERF_EN
      n_checks++;
      if (cycle_cnt !== 32'(busy_cycles)) begin
         n_fail++;
         $display("FAIL cycle_cnt_run: got %0d expected %0d", cycle_cnt, busy_cycles);
      end
`endif
   endtask

   task automatic test_full_ntt();
      int golden [N];
      load_ram();
      run_one(-1);
      for (int k = 0; k < N; k++) begin
         golden[k] = 0;
         for (int n = 0; n < N; n++)
            golden[k] = (golden[k] + (n + 1) * modpow(2, (n * k) % N)) % P;
      end
      for (int k = 0; k < N; k++) begin
         n_checks++;
         if (int'(ram[k]) !== golden[k]) begin
            n_fail++;
            $display("FAIL ntt_ram[%0d]: got %0d expected %0d", k, ram[k], golden[k]);
         end
      end
      n_checks++;
      if (bus.tag_err !== 1'b0) begin
         n_fail++;
         $display("FAIL ntt_tag_err: got %0b expected 0", bus.tag_err);
      end
   endtask

   task automatic test_start_while_busy();
      load_ram();
      run_one(3);
      n_checks++;
      if (seq_n !== 12) begin
         n_fail++;
         $display("FAIL restart_count: got %0d reads expected 12", seq_n);
      end
      for (int i = 0; i < 12; i++) begin
         n_checks++;
         if (sa[i] !== EXP_A[i] || sb[i] !== EXP_B[i] || st[i] !== EXP_TW[i]) begin
            n_fail++;
            $display("FAIL restart_seq[%0d]: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                     i, sa[i], sb[i], st[i], EXP_A[i], EXP_B[i], EXP_TW[i]);
         end
      end
      n_checks++;
      if (done_cnt !== 1) begin
         n_fail++;
         $display("FAIL restart_done: got %0d expected 1", done_cnt);
      end
   endtask

   task automatic test_tag_err();
      int rose, dropped;
      rose = 0;
      dropped = 0;
      load_ram();
      inject_req = 1'b1;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n_checks++;
      if (bus.tag_err !== 1'b0) begin
         n_fail++;
         $display("FAIL tag_err_early: got %0b expected 0", bus.tag_err);
      end
      for (int c = 0; c < 80; c++) begin
         if (bus.tag_err === 1'b1) rose = 1;
         else if (rose != 0) dropped = 1;
         @(negedge clk);
      end
      n_checks++;
      if (rose !== 1) begin
         n_fail++;
         $display("FAIL tag_err_rise: got %0d expected 1", rose);
      end
      n_checks++;
      if (dropped !== 0) begin
         n_fail++;
         $display("FAIL tag_err_sticky: got dropped=%0d expected 0", dropped);
      end
      reset = 1'b1;
      inject_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.tag_err !== 1'b0) begin
         n_fail++;
         $display("FAIL tag_err_reset: got %0b expected 0", bus.tag_err);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_in_drain();
      int reads, dones, found;
      reads = 0;
      dones = 0;
      found = 0;
      load_ram();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (bus.rd_en) reads++;
         @(negedge clk);
         if (reads == 2 * NB) begin
            found = 1;
            break;
         end
      end
      n_checks++;
      if (found !== 1) begin
         n_fail++;
         $display("FAIL drain_reach: got %0d stage reads expected %0d", reads, 2 * NB);
      end
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.rd_en, bus.bf_en, bus.wb_valid, bus.done} !== 5'b0) begin
         n_fail++;
         $display("FAIL drain_reset_ctrl: got %b expected 00000",
                  {bus.busy, bus.rd_en, bus.bf_en, bus.wb_valid, bus.done});
      end
      n_checks++;
      if (dut.outstanding !== '0) begin
         n_fail++;
         $display("FAIL drain_reset_outstanding: got %0d expected 0", dut.outstanding);
      end
`ifdef NTT_SEQ_PERF_EN
      n_checks++;
      if (cycle_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL drain_reset_cycle_cnt: got %0d expected 0", cycle_cnt);
      end
`endif
      reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (bus.done) dones++;
         @(negedge clk);
      end
      n_checks++;
      if (dones !== 0) begin
         n_fail++;
         $display("FAIL drain_no_done: got %0d expected 0", dones);
      end
      load_ram();
      run_one(-1);
      n_checks++;
      if (done_cnt !== 1 || seq_n !== 12) begin
         n_fail++;
         $display("FAIL drain_restart: got done=%0d reads=%0d expected 1 12", done_cnt, seq_n);
      end
      n_checks++;
      if (int'(ram[0]) !== 2 || int'(ram[4]) !== 13) begin
         n_fail++;
         $display("FAIL drain_restart_data: got X0=%0d X4=%0d expected 2 13", ram[0], ram[4]);
      end
`ifdef NTT_SEQ_PERF_EN
      n_checks++;
      if (cycle_cnt !== 32'(busy_cycles)) begin
         n_fail++;
         $display("FAIL drain_cycle_cnt: got %0d expected %0d", cycle_cnt, busy_cycles);
      end
`endif
   endtask

   initial begin
      bus.start = 1'b0;
      for (int k = 0; k < NB; k++) tw_rom[k] = DW'(modpow(2, k));
      test_reset();
      test_addr_sequence();
      test_stage_drain();
      test_full_ntt();
      test_start_while_busy();
      test_tag_err();
      test_reset_in_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
